// File: rtl/rgb_sched_pkg.sv
// Shared types for the RGB scheduler: FSM states, channel index and the
// tag that travels alongside each operand through the shared PU.
package rgb_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE_R,
      ISSUE_G,
      ISSUE_B,
      DRAIN,
      OUT
   } state_t;

   typedef enum logic [1:0] {
      CH_R = 2'd0,
      CH_G = 2'd1,
      CH_B = 2'd2
   } ch_t;

   typedef struct packed {
      logic valid;
      ch_t  ch;
   } tag_t;

   localparam tag_t TAG_NONE = '{valid: 1'b0, ch: CH_R};

endpackage

// File: rtl/pu_tag_pipe.sv
// P_LAT-deep shift register of channel tags, aligned with the shared PU
// latency so the output tag names the channel currently on pu_revq.
module pu_tag_pipe
   import rgb_sched_pkg::*;
#(
   parameter int P_LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  tag_t tag_in,
   output tag_t tag_out
);

   tag_t stage [P_LAT];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < P_LAT; i++) begin
            stage[i] <= TAG_NONE;
         end
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < P_LAT; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign tag_out = stage[P_LAT-1];

endmodule

// File: rtl/rgb_pu_scheduler.sv
// Time-multiplexes one single-channel pixel unit over R, G and B: operands are
// issued on consecutive cycles and the results reassembled into one pixel.
module rgb_pu_scheduler
   import rgb_sched_pkg::*;
#(
   parameter int P_IMGDEPTH = 8,
   parameter int HEIGHT     = 480,
   parameter int WIDTH      = 640,
   parameter int P_LAT      = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [$clog2(WIDTH+1)-1:0]    h_count_in,
   input  logic [$clog2(HEIGHT+1)-1:0]   v_count_in,
   input  logic [P_IMGDEPTH-1:0]         r_in,
   input  logic [P_IMGDEPTH-1:0]         g_in,
   input  logic [P_IMGDEPTH-1:0]         b_in,
   output logic [P_IMGDEPTH-1:0]         pu_q,
   input  logic [P_IMGDEPTH-1:0]         pu_revq,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(WIDTH+1)-1:0]    h_count_out,
   output logic [$clog2(HEIGHT+1)-1:0]   v_count_out,
   output logic [P_IMGDEPTH-1:0]         r_out,
   output logic [P_IMGDEPTH-1:0]         g_out,
   output logic [P_IMGDEPTH-1:0]         b_out,
   output logic                          sof_out,
   output logic                          eol_out,
   output logic                          busy
);

   localparam int HW = $clog2(WIDTH+1);
   localparam int VW = $clog2(HEIGHT+1);
   localparam int CW = (P_LAT > 1) ? $clog2(P_LAT) : 1;
   localparam logic [HW-1:0] H_LAST = HW'(WIDTH - 1);

   if (P_LAT < 1) begin : g_lat_check
      $error("rgb_pu_scheduler: P_LAT must be >= 1");
   end

   state_t                state;
   logic [CW-1:0]         drain_cnt;
   logic [P_IMGDEPTH-1:0] g_lat, b_lat;
   logic [P_IMGDEPTH-1:0] r_res, g_res;
   logic [HW-1:0]         h_lat;
   logic [VW-1:0]         v_lat;
   tag_t                  tag_in, tag_out;
   logic                  accept;
   logic                  b_done;

   // in_ready is only ever high in IDLE, so a handshake implies IDLE.
   assign accept = in_valid && in_ready;
   assign b_done = tag_out.valid && (tag_out.ch == CH_B);

   always_comb begin
      tag_in = TAG_NONE;
      case (state)
         ISSUE_R: tag_in = '{valid: 1'b1, ch: CH_R};
         ISSUE_G: tag_in = '{valid: 1'b1, ch: CH_G};
         ISSUE_B: tag_in = '{valid: 1'b1, ch: CH_B};
         default: tag_in = TAG_NONE;
      endcase
   end

   pu_tag_pipe #(
      .P_LAT (P_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   // R is sent straight from r_in on the accept edge, so only G/B need holding.
   always_ff @(posedge clk) begin
      if (accept) begin
         g_lat <= g_in;
         b_lat <= b_in;
         h_lat <= h_count_in;
         v_lat <= v_count_in;
      end
      if (tag_out.valid && tag_out.ch == CH_R) r_res <= pu_revq;
      if (tag_out.valid && tag_out.ch == CH_G) g_res <= pu_revq;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         drain_cnt   <= '0;
         in_ready    <= 1'b0;
         busy        <= 1'b0;
         pu_q        <= '0;
         out_valid   <= 1'b0;
         sof_out     <= 1'b0;
         eol_out     <= 1'b0;
         r_out       <= '0;
         g_out       <= '0;
         b_out       <= '0;
         h_count_out <= '0;
         v_count_out <= '0;
      end else begin
         pu_q <= '0;
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (accept) begin
                  state    <= ISSUE_R;
                  pu_q     <= r_in;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            ISSUE_R: begin
               state <= ISSUE_G;
               pu_q  <= g_lat;
            end
            ISSUE_G: begin
               state <= ISSUE_B;
               pu_q  <= b_lat;
            end
            ISSUE_B: begin
               if (P_LAT == 1) begin
                  state <= OUT;
               end else begin
                  state     <= DRAIN;
                  drain_cnt <= CW'(P_LAT - 1);
               end
            end
            DRAIN: begin
               if (drain_cnt == CW'(1)) state <= OUT;
               else                     drain_cnt <= drain_cnt - 1'b1;
            end
            OUT: begin
               // B result is bypassed straight into the output register.
               if (out_valid) begin
                  if (out_ready) begin
                     out_valid <= 1'b0;
                     state     <= IDLE;
                     busy      <= 1'b0;
                     in_ready  <= 1'b1;
                  end
               end else if (b_done) begin
                  out_valid   <= 1'b1;
                  r_out       <= r_res;
                  g_out       <= g_res;
                  b_out       <= pu_revq;
                  h_count_out <= h_lat;
                  v_count_out <= v_lat;
                  sof_out     <= (h_lat == '0) && (v_lat == '0);
                  eol_out     <= (h_lat == H_LAST);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rgb_pu_scheduler.sv
// Bench for rgb_pu_scheduler: two instances (P_LAT=1 and P_LAT=3) each with a
// bit-reversal PU model, driven by directed and randomized pixel transactions.
module tb_rgb_pu_scheduler;
   import rgb_sched_pkg::*;

   localparam int HW = 10;
   localparam int VW = 9;

   typedef struct packed {
      logic [7:0]    r;
      logic [7:0]    g;
      logic [7:0]    b;
      logic [HW-1:0] h;
      logic [VW-1:0] v;
   } px_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          rst [2];
   logic          in_valid [2], in_ready [2], out_valid [2], out_ready [2];
   logic          sof_out [2], eol_out [2], busy [2];
   logic [7:0]    r_in [2], g_in [2], b_in [2], pu_q [2], pu_revq [2];
   logic [7:0]    r_out [2], g_out [2], b_out [2];
   logic [HW-1:0] h_in [2], h_out [2];
   logic [VW-1:0] v_in [2], v_out [2];

   int vectors = 0;
   int miscompares = 0;
   int last_acc [2];

   function automatic logic [7:0] rev8(input logic [7:0] x);
      logic [7:0] y;
      for (int i = 0; i < 8; i++) y[i] = x[7-i];
      return y;
   endfunction

   // Shared-PU models: bit reversal with 1 and 3 register stages.
   logic [7:0] pu0_s;
   logic [7:0] pu1_s [3];
   always @(posedge clk) begin
      pu0_s    <= rev8(pu_q[0]);
      pu1_s[0] <= rev8(pu_q[1]);
      pu1_s[1] <= pu1_s[0];
      pu1_s[2] <= pu1_s[1];
   end
   always_comb begin
      pu_revq[0] = pu0_s;
      pu_revq[1] = pu1_s[2];
   end

   rgb_pu_scheduler #(.P_IMGDEPTH(8), .HEIGHT(480), .WIDTH(640), .P_LAT(1)) u_dut0 (
      .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .h_count_in(h_in[0]), .v_count_in(v_in[0]),
      .r_in(r_in[0]), .g_in(g_in[0]), .b_in(b_in[0]),
      .pu_q(pu_q[0]), .pu_revq(pu_revq[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .h_count_out(h_out[0]), .v_count_out(v_out[0]),
      .r_out(r_out[0]), .g_out(g_out[0]), .b_out(b_out[0]),
      .sof_out(sof_out[0]), .eol_out(eol_out[0]), .busy(busy[0])
   );

   rgb_pu_scheduler #(.P_IMGDEPTH(8), .HEIGHT(480), .WIDTH(640), .P_LAT(3)) u_dut1 (
      .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .h_count_in(h_in[1]), .v_count_in(v_in[1]),
      .r_in(r_in[1]), .g_in(g_in[1]), .b_in(b_in[1]),
      .pu_q(pu_q[1]), .pu_revq(pu_revq[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .h_count_out(h_out[1]), .v_count_out(v_out[1]),
      .r_out(r_out[1]), .g_out(g_out[1]), .b_out(b_out[1]),
      .sof_out(sof_out[1]), .eol_out(eol_out[1]), .busy(busy[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input int d, input string tag, input px_t p);
      chk({tag, "_r"}, r_out[d], rev8(p.r));
      chk({tag, "_g"}, g_out[d], rev8(p.g));
      chk({tag, "_b"}, b_out[d], rev8(p.b));
      chk({tag, "_h"}, h_out[d], p.h);
      chk({tag, "_v"}, v_out[d], p.v);
      chk({tag, "_sof"}, sof_out[d], (p.h == 0 && p.v == 0));
      chk({tag, "_eol"}, eol_out[d], (p.h == 639));
   endtask

   // One full transaction with exact cycle-level expectations.
   task automatic run_pixel(input int d, input px_t p, input int stall, input bit keep_valid);
      int lat;
      bit ok;
      lat = (d == 0) ? 1 : 3;
      r_in[d] = p.r; g_in[d] = p.g; b_in[d] = p.b;
      h_in[d] = p.h; v_in[d] = p.v;
      in_valid[d] = 1'b1;
      out_ready[d] = 1'($urandom_range(0, 1));
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         if (in_ready[d]) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      if (!ok) begin
         chk("accept_timeout", 0, 1);
         in_valid[d] = 1'b0;
         return;
      end
      step();
      last_acc[d] = cyc;
      if (!keep_valid) in_valid[d] = 1'b0;
      chk("pu_q_r", pu_q[d], p.r);
      chk("busy", busy[d], 1);
      step();
      chk("pu_q_g", pu_q[d], p.g);
      chk("in_ready_busy", in_ready[d], 0);
      step();
      chk("pu_q_b", pu_q[d], p.b);
      for (int k = 0; k < lat; k++) begin
         step();
         chk("early_valid", out_valid[d], 0);
         chk("pu_q_idle", pu_q[d], 0);
         if (d == 1) chk("drain_state", (u_dut1.state == DRAIN), (k < lat - 1));
      end
      step();
      chk("out_valid", out_valid[d], 1);
      chk_out(d, "out", p);
      out_ready[d] = (stall == 0);
      for (int s = 0; s < stall; s++) begin
         step();
         chk("stall_valid", out_valid[d], 1);
         chk("stall_in_ready", in_ready[d], 0);
         chk_out(d, "stall", p);
         if (s == stall - 1) out_ready[d] = 1'b1;
      end
      step();
      chk("done_valid", out_valid[d], 0);
      chk("done_in_ready", in_ready[d], 1);
      chk("done_busy", busy[d], 0);
   endtask

   function automatic px_t rand_px();
      px_t p;
      p.r = 8'($urandom);
      p.g = 8'($urandom);
      p.b = 8'($urandom);
      case ($urandom_range(0, 3))
         0:       begin p.h = 10'd0;   p.v = 9'd0; end
         1:       begin p.h = 10'd639; p.v = 9'($urandom_range(0, 479)); end
         default: begin p.h = 10'($urandom_range(0, 639)); p.v = 9'($urandom_range(0, 479)); end
      endcase
      return p;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      px_t p;
      int  prev;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
         r_in[d] = '0; g_in[d] = '0; b_in[d] = '0; h_in[d] = '0; v_in[d] = '0;
      end
      step(); step(); step();
      for (int d = 0; d < 2; d++) begin
         chk("rst_in_ready", in_ready[d], 0);
         chk("rst_out_valid", out_valid[d], 0);
         chk("rst_busy", busy[d], 0);
         chk("rst_pu_q", pu_q[d], 0);
         chk("rst_r_out", r_out[d], 0);
         chk("rst_sof", sof_out[d], 0);
         chk("rst_eol", eol_out[d], 0);
         rst[d] = 1'b1;
      end
      step();
      chk("rel_in_ready0", in_ready[0], 1);
      chk("rel_in_ready1", in_ready[1], 1);

      // Directed pixel with P_LAT=1
      p = '{r: 8'h01, g: 8'h0F, b: 8'hAA, h: 10'd5, v: 9'd2};
      run_pixel(0, p, 0, 0);
      chk("t1_r", r_out[0], 8'h80);
      chk("t1_g", g_out[0], 8'hF0);
      chk("t1_b", b_out[0], 8'h55);

      // Backpressure: ten stalled cycles
      run_pixel(0, rand_px(), 10, 0);

      // in_valid held high: one acceptance every 6 cycles
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         p = rand_px();
         p.r = 8'(i * 16 + 3);
         run_pixel(0, p, 0, 1);
         if (i > 0) chk("b2b_period", last_acc[0] - prev, 6);
         prev = last_acc[0];
      end
      in_valid[0] = 1'b0;

      // P_LAT=3 with DRAIN
      p = '{r: 8'h03, g: 8'h30, b: 8'hFF, h: 10'd17, v: 9'd9};
      run_pixel(1, p, 0, 0);
      chk("t4_r", r_out[1], 8'hC0);
      chk("t4_g", g_out[1], 8'h0C);
      chk("t4_b", b_out[1], 8'hFF);

      // Frame / line markers
      p = '{r: 8'h11, g: 8'h22, b: 8'h33, h: 10'd0, v: 9'd0};
      run_pixel(0, p, 0, 0);
      chk("t5_sof_a", sof_out[0], 1);
      chk("t5_eol_a", eol_out[0], 0);
      p = '{r: 8'h44, g: 8'h55, b: 8'h66, h: 10'd639, v: 9'd7};
      run_pixel(0, p, 0, 0);
      chk("t5_sof_b", sof_out[0], 0);
      chk("t5_eol_b", eol_out[0], 1);

      // Reset asserted while G is being issued
      p = '{r: 8'h5A, g: 8'hC3, b: 8'h0F, h: 10'd100, v: 9'd50};
      r_in[0] = p.r; g_in[0] = p.g; b_in[0] = p.b; h_in[0] = p.h; v_in[0] = p.v;
      in_valid[0] = 1'b1;
      out_ready[0] = 1'b1;
      for (int n = 0; n < 20 && !in_ready[0]; n++) step();
      step();
      in_valid[0] = 1'b0;
      step();
      chk("t6_pre_pu_q", pu_q[0], p.g);
      rst[0] = 1'b0;
      #1;
      chk("t6_async_pu_q", pu_q[0], 0);
      chk("t6_async_busy", busy[0], 0);
      chk("t6_async_r_out", r_out[0], 0);
      chk("t6_async_h_out", h_out[0], 0);
      chk("t6_async_eol", eol_out[0], 0);
      step();
      chk("t6_hold_in_ready", in_ready[0], 0);
      rst[0] = 1'b1;
      step();
      chk("t6_rel_in_ready", in_ready[0], 1);
      for (int n = 0; n < 8; n++) begin
         step();
         chk("t6_no_output", out_valid[0], 0);
      end
      run_pixel(0, rand_px(), 1, 0);

      // Randomized transactions on both latencies
      for (int i = 0; i < 40; i++) begin
         int d;
         d = $urandom_range(0, 1);
         for (int g = 0; g < $urandom_range(0, 2); g++) step();
         run_pixel(d, rand_px(), $urandom_range(0, 3), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rgb_pu_scheduler.md
Name: rgb_pu_scheduler

Overview:
Time-multiplexes one shared single-channel pixel-processing unit (PU) across the R, G and B channels. It replaces three PU instances with one, at the cost of throughput.
- Accepts one RGB pixel plus its h/v counts over a valid/ready handshake.
- Issues R, G, B to the PU on consecutive cycles and collects the results after the PU latency.
- Presents the reassembled pixel downstream with frame/line markers.
- Sits between the pixel source and the sink of the image-processing wrapper; the PU instance lives outside this block.

Parameters:
P_IMGDEPTH, 8, bits per colour channel
HEIGHT, 480, active lines per frame
WIDTH, 640, active pixels per line
P_LAT, 1, PU latency in clk cycles (>=1; elaboration error if <1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  input pixel valid
in_ready  output  1  block can accept a pixel
h_count_in  input  $clog2(WIDTH+1)  pixel column of input
v_count_in  input  $clog2(HEIGHT+1)  pixel line of input
r_in/g_in/b_in  input  P_IMGDEPTH each  input channels
pu_q  output  P_IMGDEPTH  operand to shared PU
pu_revq  input  P_IMGDEPTH  PU result, P_LAT cycles after pu_q
out_valid  output  1  output pixel valid
out_ready  input  1  sink accepts output
h_count_out/v_count_out  output  as inputs  counts travelling with pixel
r_out/g_out/b_out  output  P_IMGDEPTH each  processed channels
sof_out  output  1  output pixel is h=0,v=0 (qualified by out_valid)
eol_out  output  1  output pixel is h=WIDTH-1 (qualified by out_valid)
busy  output  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; in_ready=0; out_valid, sof_out, eol_out, busy=0; pu_q=0; all data/count outputs=0; tag pipe cleared.
- in_ready=1 only in IDLE with rst=1, so it goes high in the first cycle after reset release.
- FSM states: IDLE -> ISSUE_R -> ISSUE_G -> ISSUE_B -> DRAIN -> OUT -> IDLE.
- IDLE:
  - On in_valid&in_ready at edge t0, latch r/g/b/h/v and go to ISSUE_R.
  - in_valid without in_ready is ignored; the source holds its data.
- ISSUE_R/G/B (cycles t0+1..t0+3):
  - pu_q = latched R, G, B respectively.
  - Push a tag (valid, channel index 0/1/2) into a P_LAT-deep tag pipe.
  - pu_q=0 in every other state.
- Capture: when the tag pipe output is valid, pu_revq is written into result channel [tag index]. B is captured in cycle t0+3+P_LAT.
- DRAIN: wait until the B capture, then go to OUT. DRAIN lasts P_LAT-1 cycles; it is skipped when P_LAT=1.
- OUT:
  - out_valid=1 from cycle t0+4+P_LAT (t0+5 for P_LAT=1).
  - r/g/b_out, h/v_count_out, sof_out, eol_out are registered and stable while out_valid=1.
  - Hold until out_ready=1, then on that edge out_valid=0 and go to IDLE.
  - No new pixel is accepted in OUT.
- Throughput: one pixel per 5+P_LAT cycles with out_ready tied high.
- out_ready held 0 indefinitely: the block stalls in OUT and in_ready stays 0.
- out_ready=1 while out_valid=0 has no effect.
- sof_out = (h==0 && v==0); eol_out = (h==WIDTH-1). Both are compared on the latched counts, and both may be 1 only if WIDTH=1.
- Counts pass through unmodified; no range checking is done.
- Reset mid-operation: the in-flight pixel is dropped with no output. In-flight PU results after release are ignored because the tag pipe was cleared.
- Result registers are widths-exact; no arithmetic on channel data.

Decomposition:
- Shared package rgb_sched_pkg:
  - state enum (IDLE, ISSUE_R, ISSUE_G, ISSUE_B, DRAIN, OUT);
  - channel index typedef (2-bit: CH_R=0, CH_G=1, CH_B=2);
  - tag struct {valid, ch}.
- One sub-module pu_tag_pipe:
  - parameterised P_LAT-deep shift register of tags;
  - async active-low clear, same clk/rst;
  - outputs the aligned capture tag.

Test Plan:
The bench PU model is an 8-bit bit-reversal with P_LAT register stages.
1. P_LAT=1, pixel r=0x01, g=0x0F, b=0xAA, h=5, v=2 accepted at t0 -> pu_q = 0x01, 0x0F, 0xAA at t0+1..t0+3; out_valid at t0+5 with r_out=0x80, g_out=0xF0, b_out=0x55, h=5, v=2, sof=0, eol=0.
2. out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0 throughout; the pixel completes on the first out_ready=1 edge, then in_ready=1 next cycle.
3. in_valid held high with 4 distinct pixels, out_ready=1 -> pixels accepted exactly every 6 cycles, outputs in order, none lost or duplicated.
4. P_LAT=3, r=0x03, g=0x30, b=0xFF -> out_valid at t0+7 with 0xC0, 0x0C, 0xFF; DRAIN observed for 2 cycles.
5. Pixels with h=0,v=0 and h=WIDTH-1=639,v=7 -> sof_out=1 only on the first, eol_out=1 only on the second.
6. rst pulsed low during ISSUE_G -> all outputs 0 immediately; after release in_ready=1, no out_valid for the dropped pixel, and the next pixel processes correctly.
